retire_trace_buffer: RTL and testbench

Debug trace capture block sitting directly downstream of `processor`, consuming its per-cycle debug outputs (`prog_count`, `instr_opcode`, `write_reg_addr`, `write_reg_data`). After being armed, it waits for a trigger PC, then records one retire record per clock into a FIFO. A host-side consumer drains the FIFO through a valid/ready handshake. Overflow is tracked with a sticky flag and a saturating drop counter.

---
 rtl/retire_trace_buffer_pkg.sv | 21 ++
 rtl/retire_trace_buffer_trace_fifo.sv | 56 +++++
 rtl/retire_trace_buffer.sv | 126 ++++++++++++
 tb/tb_retire_trace_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_buffer_pkg.sv
// Shared constants for the retire trace buffer: FSM state encoding,
// record field widths and a saturating increment helper.
package retire_trace_buffer_pkg;

    typedef enum logic [1:0] {
        TRC_IDLE    = 2'b00,
        TRC_ARMED   = 2'b01,
        TRC_CAPTURE = 2'b10
    } trc_state_t;

    localparam int OPCODE_W   = 6;
    localparam int REG_ADDR_W = 5;
    localparam int TSTAMP_W   = 16;

    localparam logic [TSTAMP_W-1:0] CNT_MAX = 16'hFFFF;

    function automatic logic [TSTAMP_W-1:0] sat_inc(input logic [TSTAMP_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/retire_trace_buffer_trace_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed retire records.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module trace_fifo #(
    parameter int WIDTH  = 91,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Storage is never reset, so mask the head while empty to present zeros.
    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace capture: arm, wait for a trigger PC, then push one timestamped
// record per cycle into a FIFO drained through a valid/ready handshake.
module retire_trace_buffer
    import retire_trace_buffer_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  stop,
    input  logic [WORD_SIZE-1:0]  trig_pc,
    input  logic [WORD_SIZE-1:0]  prog_count,
    input  logic [OPCODE_W-1:0]   instr_opcode,
    input  logic [REG_ADDR_W-1:0] write_reg_addr,
    input  logic [WORD_SIZE-1:0]  write_reg_data,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic [WORD_SIZE-1:0]  rec_pc,
    output logic [OPCODE_W-1:0]   rec_opcode,
    output logic [REG_ADDR_W-1:0] rec_wr_addr,
    output logic [WORD_SIZE-1:0]  rec_wr_data,
    output logic [TSTAMP_W-1:0]   rec_tstamp,
    output logic [1:0]            state,
    output logic [ADDR_W:0]       fill_level,
    output logic                  overflow,
    output logic [15:0]           drop_count
);
    localparam int REC_W = 2*WORD_SIZE + OPCODE_W + REG_ADDR_W + TSTAMP_W;

    trc_state_t          state_q, state_d;
    logic [TSTAMP_W-1:0] tstamp_q;
    logic                overflow_q;
    logic [15:0]         drop_q;
    logic                push_req;
    logic                arm_fire;
    logic                pop_fire;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [REC_W-1:0]    push_rec;
    logic [REC_W-1:0]    head_rec;

    // Stop wins over a same-cycle trigger, and the stop-cycle record is dropped.
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        arm_fire = 1'b0;
        unique case (state_q)
            TRC_IDLE: begin
                if (arm) begin
                    state_d  = TRC_ARMED;
                    arm_fire = 1'b1;
                end
            end
            TRC_ARMED: begin
                if (stop) begin
                    state_d = TRC_IDLE;
                end else if (prog_count == trig_pc) begin
                    state_d  = TRC_CAPTURE;
                    push_req = 1'b1;
                end
            end
            TRC_CAPTURE: begin
                if (stop)
                    state_d = TRC_IDLE;
                else
                    push_req = 1'b1;
            end
            default: state_d = TRC_IDLE;
        endcase
    end

    assign rec_valid = ~fifo_empty;
    assign pop_fire  = rec_valid & rec_ready;
    assign drop      = push_req & fifo_full & ~pop_fire;

    // Timestamp is zero while armed, so the trigger record carries tstamp 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= TRC_IDLE;
            tstamp_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q <= state_d;
            if (arm_fire) begin
                tstamp_q   <= '0;
                overflow_q <= 1'b0;
                drop_q     <= '0;
            end else begin
                if (push_req)
                    tstamp_q <= sat_inc(tstamp_q);
                if (drop) begin
                    overflow_q <= 1'b1;
                    drop_q     <= sat_inc(drop_q);
                end
            end
        end
    end

    assign push_rec = {prog_count, instr_opcode, write_reg_addr, write_reg_data, tstamp_q};

    trace_fifo #(
        .WIDTH  (REC_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop_fire),
        .din   (push_rec),
        .dout  (head_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_level)
    );

    assign {rec_pc, rec_opcode, rec_wr_addr, rec_wr_data, rec_tstamp} = head_rec;

    assign state      = state_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: table-driven vectors, directed
// corner-case sequences and a randomized run against a queue-based model.
module tb_retire_trace_buffer;

    localparam int WS    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          stop;
    logic [WS-1:0] trig_pc;
    logic [WS-1:0] prog_count;
    logic [5:0]    instr_opcode;
    logic [4:0]    write_reg_addr;
    logic [WS-1:0] write_reg_data;
    logic          rec_valid;
    logic          rec_ready;
    logic [WS-1:0] rec_pc;
    logic [5:0]    rec_opcode;
    logic [4:0]    rec_wr_addr;
    logic [WS-1:0] rec_wr_data;
    logic [15:0]   rec_tstamp;
    logic [1:0]    state;
    logic [AW:0]   fill_level;
    logic          overflow;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    retire_trace_buffer #(.WORD_SIZE(WS), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .stop           (stop),
        .trig_pc        (trig_pc),
        .prog_count     (prog_count),
        .instr_opcode   (instr_opcode),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_pc         (rec_pc),
        .rec_opcode     (rec_opcode),
        .rec_wr_addr    (rec_wr_addr),
        .rec_wr_data    (rec_wr_data),
        .rec_tstamp     (rec_tstamp),
        .state          (state),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    typedef struct {
        logic [WS-1:0] pc;
        logic [5:0]    op;
        logic [4:0]    wa;
        logic [WS-1:0] wd;
        logic [15:0]   ts;
    } rec_t;

    typedef struct {
        logic          rn;
        logic          a;
        logic          s;
        logic          r;
        logic [WS-1:0] pc;
        logic [1:0]    exp_state;
        logic [AW:0]   exp_fill;
        logic          exp_valid;
    } vec_t;

    // Reference model: mode 0=idle 1=armed 2=capture, plus a record queue.
    rec_t        mq[$];
    int          m_state;
    logic        m_ovf;
    logic [15:0] m_drops;
    logic [15:0] m_ts;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelStep(input logic rn, input logic a, input logic s, input logic r,
                             input logic [WS-1:0] pc, input logic [WS-1:0] trig,
                             input logic [5:0] op, input logic [4:0] wa, input logic [WS-1:0] wd);
        rec_t rec;
        bit   do_pop;
        bit   do_push;
        if (!rn) begin
            mq.delete();
            m_state = 0;
            m_ovf   = 1'b0;
            m_drops = '0;
            m_ts    = '0;
            return;
        end
        do_pop  = r && (mq.size() > 0);
        do_push = 1'b0;
        case (m_state)
            0: if (a) begin
                   m_state = 1;
                   m_ovf   = 1'b0;
                   m_drops = '0;
                   m_ts    = '0;
               end
            1: if (s) m_state = 0;
               else if (pc == trig) begin
                   m_state = 2;
                   do_push = 1'b1;
               end
            default: if (s) m_state = 0;
                     else do_push = 1'b1;
        endcase
        if (do_pop)
            void'(mq.pop_front());
        if (do_push) begin
            rec = '{pc, op, wa, wd, m_ts};
            if (mq.size() < DEPTH) begin
                mq.push_back(rec);
            end else begin
                m_ovf = 1'b1;
                if (m_drops != 16'hFFFF) m_drops++;
            end
            if (m_ts != 16'hFFFF) m_ts++;
        end
    endtask

    task automatic checkOutput();
        checkVal("state", state, m_state);
        checkVal("fill_level", fill_level, mq.size());
        checkVal("rec_valid", rec_valid, mq.size() > 0);
        checkVal("overflow", overflow, m_ovf);
        checkVal("drop_count", drop_count, m_drops);
        if (mq.size() > 0) begin
            checkVal("rec_pc", rec_pc, mq[0].pc);
            checkVal("rec_opcode", rec_opcode, mq[0].op);
            checkVal("rec_wr_addr", rec_wr_addr, mq[0].wa);
            checkVal("rec_wr_data", rec_wr_data, mq[0].wd);
            checkVal("rec_tstamp", rec_tstamp, mq[0].ts);
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic a, input logic s, input logic r,
                                 input logic [WS-1:0] pc, input logic [WS-1:0] trig);
        rst            = rn;
        arm            = a;
        stop           = s;
        rec_ready      = r;
        prog_count     = pc;
        trig_pc        = trig;
        instr_opcode   = 6'($urandom);
        write_reg_addr = 5'($urandom);
        write_reg_data = $urandom;
        modelStep(rn, a, s, r, pc, trig, instr_opcode, write_reg_addr, write_reg_data);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    vec_t tbl[11];

    initial begin
        int ready_pct;
        rst = 1'b0; arm = 1'b0; stop = 1'b0; rec_ready = 1'b0;
        trig_pc = 32'h10; prog_count = '0;
        instr_opcode = '0; write_reg_addr = '0; write_reg_data = '0;

        // Reset, idle pass over trig_pc, then arm/trigger/stop at 0x18.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 5'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 2'd0, 5'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 2'd0, 5'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 2'd0, 5'd0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 2'd1, 5'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h04, 2'd1, 5'd0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h08, 2'd1, 5'd0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0C, 2'd1, 5'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 2'd2, 5'd1, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 2'd2, 5'd2, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h18, 2'd0, 5'd2, 1'b1};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].rn, tbl[i].a, tbl[i].s, tbl[i].r, tbl[i].pc, 32'h10);
            checkVal("tbl_state", state, tbl[i].exp_state);
            checkVal("tbl_fill", fill_level, tbl[i].exp_fill);
            checkVal("tbl_valid", rec_valid, tbl[i].exp_valid);
            if (i == 0) begin
                checkVal("reset_rec_pc", rec_pc, 0);
                checkVal("reset_rec_tstamp", rec_tstamp, 0);
                checkVal("reset_drop_count", drop_count, 0);
            end
        end

        checkVal("trig_head_pc", rec_pc, 32'h10);
        checkVal("trig_head_ts", rec_tstamp, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h10);
        checkVal("second_head_pc", rec_pc, 32'h14);
        checkVal("second_head_ts", rec_tstamp, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h10);
        checkVal("drained_valid", rec_valid, 0);

        // Overflow: 20 capture cycles with no consumer.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h100);
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(4*i), 32'h100);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100);
        checkVal("ovf_fill", fill_level, 16);
        checkVal("ovf_flag", overflow, 1);
        checkVal("ovf_drops", drop_count, 4);

        // Re-arm clears the overflow status but keeps the stored records.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h100);
        checkVal("rearm_ovf", overflow, 0);
        checkVal("rearm_drops", drop_count, 0);
        checkVal("rearm_fill", fill_level, 16);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100);
        for (int i = 0; i < 16; i++) begin
            checkVal("ovf_drain_ts", rec_tstamp, i);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h100);
        end
        checkVal("ovf_drain_empty", rec_valid, 0);

        // Full FIFO with a simultaneous pop every cycle: no drops.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200);
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h200);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h200);
        checkVal("fullpop_drops", drop_count, 0);
        checkVal("fullpop_fill", fill_level, 16);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200);
        for (int i = 0; i < 16; i++) begin
            checkVal("fullpop_ts", rec_tstamp, 10 + i);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h200);
        end

        // Stop in the trigger cycle: back to idle, nothing pushed.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h40);
        checkVal("collide_state", state, 0);
        checkVal("collide_fill", fill_level, 0);

        // Reset while capturing with five records stored.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h40);
        checkVal("pre_reset_fill", fill_level, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h40);
        checkVal("midreset_fill", fill_level, 0);
        checkVal("midreset_valid", rec_valid, 0);
        checkVal("midreset_state", state, 0);
        checkVal("midreset_rec_pc", rec_pc, 0);

        // Randomized traffic with changing consumer throughput.
        ready_pct = 50;
        for (int i = 0; i < 900; i++) begin
            if (i % 150 == 0) ready_pct = (i / 150) % 3 == 0 ? 90 : ((i / 150) % 3 == 1 ? 10 : 50);
            applyStimulus($urandom_range(0, 299) != 0,
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 99) < ready_pct,
                          $urandom_range(0, 3) == 0 ? 32'h40 : $urandom,
                          32'h40);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
